// File: rtl/dcache_fifo_writer.sv
// Write side of the dcache store/victim FIFOs: sorts {index, tag, data} writes into
// per-set FIFOs, coalesces repeated {index, tag} writes and drains heads to memory.
module dcache_fifo_writer #(
    parameter int unsigned NUM_FIFO     = 4,
    parameter int unsigned FIFO_SIZE    = 4,
    parameter int unsigned NUM_SET_BITS = 5,
    parameter int unsigned NUM_TAG_BITS = 8,
    parameter int unsigned ENTRY_W      = NUM_SET_BITS + NUM_TAG_BITS + 64
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          wr_en,
    input  logic [NUM_SET_BITS-1:0]                       wr_index,
    input  logic [NUM_TAG_BITS-1:0]                       wr_tag,
    input  logic [63:0]                                   wr_data,
    output logic                                          wr_ready,
    output logic [NUM_FIFO-1:0][FIFO_SIZE-1:0][ENTRY_W-1:0] FIFO,
    output logic [NUM_FIFO-1:0][FIFO_SIZE-1:0]            fifo_entry_valid,
    output logic                                          mem_req,
    output logic [NUM_TAG_BITS+NUM_SET_BITS-1:0]          mem_addr,
    output logic [63:0]                                   mem_data,
    input  logic                                          mem_ack,
    output logic                                          all_empty
);

    localparam int unsigned CntW   = $clog2(FIFO_SIZE + 1);
    localparam int unsigned SlotW  = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam int unsigned PtrW   = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
    localparam int unsigned IdxLsb = NUM_TAG_BITS + 64;
    localparam int unsigned AddrW  = NUM_TAG_BITS + NUM_SET_BITS;

    typedef enum logic [0:0] {StIdle, StDrain} state_t;

    logic [NUM_FIFO-1:0][FIFO_SIZE-1:0][ENTRY_W-1:0] fifo_q, fifo_d;
    logic [NUM_FIFO-1:0][CntW-1:0] count_q, count_d;
    state_t                        state_q, state_d;
    logic [PtrW-1:0]               sel_q, sel_d, rr_q, rr_d;
    logic                          mem_req_q, mem_req_d;
    logic [AddrW-1:0]              mem_addr_q, mem_addr_d;
    logic [63:0]                   mem_data_q, mem_data_d;

    logic                          bound_hit, tag_hit, empty_found;
    logic [PtrW-1:0]               bound_f, empty_f, pick_f;
    logic [SlotW-1:0]              hit_slot, wr_slot;
    logic                          head_locked, do_coal, do_app, do_alloc, accept, pop;
    logic                          pick_found;
    int                            cand;
    logic [ENTRY_W-1:0]            new_entry;

    assign new_entry = {wr_index, wr_tag, wr_data};

    // Classify the incoming write against current contents: bound FIFO, tag hit, free FIFO.
    always_comb begin
        bound_hit   = 1'b0;
        bound_f     = '0;
        tag_hit     = 1'b0;
        hit_slot    = '0;
        empty_found = 1'b0;
        empty_f     = '0;
        for (int f = 0; f < int'(NUM_FIFO); f++) begin
            if (count_q[f] == '0) begin
                if (!empty_found) begin
                    empty_found = 1'b1;
                    empty_f     = PtrW'(f);
                end
            end else if (fifo_q[f][0][IdxLsb +: NUM_SET_BITS] == wr_index) begin
                bound_hit = 1'b1;
                bound_f   = PtrW'(f);
                for (int s = 0; s < int'(FIFO_SIZE); s++) begin
                    if ((CntW'(s) < count_q[f]) && (fifo_q[f][s][64 +: NUM_TAG_BITS] == wr_tag)) begin
                        tag_hit  = 1'b1;
                        hit_slot = SlotW'(s);
                    end
                end
            end
        end
    end

    // The head under DRAIN is already latched on mem_data, so it must not change.
    assign head_locked = (state_q == StDrain) && (sel_q == bound_f) && (hit_slot == '0);
    assign do_coal     = tag_hit && !head_locked;
    assign do_app      = bound_hit && !tag_hit && (count_q[bound_f] < CntW'(FIFO_SIZE));
    assign do_alloc    = !bound_hit && empty_found;
    assign wr_ready    = do_coal || do_app || do_alloc;
    assign accept      = wr_en && wr_ready;
    assign pop         = (state_q == StDrain) && mem_ack;

    // Storage next state: apply the pop shift first, then place the write post-shift.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        wr_slot = '0;
        for (int f = 0; f < int'(NUM_FIFO); f++) begin
            if (pop && (sel_q == PtrW'(f))) begin
                for (int s = 0; s < int'(FIFO_SIZE) - 1; s++) begin
                    fifo_d[f][s] = fifo_q[f][s+1];
                end
                fifo_d[f][FIFO_SIZE-1] = '0;
                count_d[f]             = count_q[f] - CntW'(1);
            end
        end
        if (accept) begin
            if (do_coal) begin
                wr_slot = (pop && (sel_q == bound_f)) ? hit_slot - SlotW'(1) : hit_slot;
                fifo_d[bound_f][wr_slot][63:0] = wr_data;
            end else if (do_app) begin
                wr_slot                 = SlotW'(count_d[bound_f]);
                fifo_d[bound_f][wr_slot] = new_entry;
                count_d[bound_f]        = count_d[bound_f] + CntW'(1);
            end else begin
                fifo_d[empty_f][0] = new_entry;
                count_d[empty_f]   = CntW'(1);
            end
        end
    end

    // Drain FSM: round-robin pick of a non-empty FIFO, hold the request until mem_ack.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        pick_found = 1'b0;
        pick_f     = '0;
        cand       = 0;
        for (int i = 0; i < int'(NUM_FIFO); i++) begin
            cand = (int'(rr_q) + i) % int'(NUM_FIFO);
            if (!pick_found && (count_q[cand] != '0)) begin
                pick_found = 1'b1;
                pick_f     = PtrW'(cand);
            end
        end
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    sel_d      = pick_f;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {fifo_q[pick_f][0][64 +: NUM_TAG_BITS],
                                  fifo_q[pick_f][0][IdxLsb +: NUM_SET_BITS]};
                    mem_data_d = fifo_q[pick_f][0][63:0];
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                    rr_d      = (sel_q == PtrW'(NUM_FIFO - 1)) ? '0 : sel_q + PtrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_q     <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            sel_q      <= '0;
            rr_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Slot valid bits and the global empty flag follow directly from the counts.
    always_comb begin
        fifo_entry_valid = '0;
        for (int f = 0; f < int'(NUM_FIFO); f++) begin
            for (int s = 0; s < int'(FIFO_SIZE); s++) begin
                fifo_entry_valid[f][s] = (CntW'(s) < count_q[f]);
            end
        end
        all_empty = (count_q == '0);
    end

    assign FIFO     = fifo_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_dcache_fifo_writer.sv
// Bench for dcache_fifo_writer: directed vector table, corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_dcache_fifo_writer;

    localparam int NF = 4;
    localparam int FS = 4;
    localparam int EW = 77;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       wr_en;
    logic [4:0]                 wr_index;
    logic [7:0]                 wr_tag;
    logic [63:0]                wr_data;
    logic                       wr_ready;
    logic [3:0][3:0][EW-1:0]    fifo_out;
    logic [3:0][3:0]            vld;
    logic                       mem_req;
    logic [12:0]                mem_addr;
    logic [63:0]                mem_data;
    logic                       mem_ack;
    logic                       all_empty;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_fifo_writer dut (
        .clock            (clock),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_index         (wr_index),
        .wr_tag           (wr_tag),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .FIFO             (fifo_out),
        .fifo_entry_valid (vld),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_ack          (mem_ack),
        .all_empty        (all_empty)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: per-FIFO queues of {tag, data} ----------------
    typedef struct packed { logic [7:0] tag; logic [63:0] data; } ent_t;
    ent_t       mq [NF][$];
    logic [4:0] mi [NF];
    bit         mbusy;
    int         msel, mrr;
    logic       mreq;
    logic [12:0] maddr;
    logic [63:0] mdata;

    task automatic m_reset();
        for (int i = 0; i < NF; i++) begin
            mq[i].delete();
            mi[i] = '0;
        end
        mbusy = 0; msel = 0; mrr = 0; mreq = 0; maddr = '0; mdata = '0;
    endtask

    // kind: 0 refused, 1 coalesce, 2 append, 3 allocate
    task automatic m_classify(input logic [4:0] idx, input logic [7:0] tag,
                              output int kind, output int f);
        int bf = -1;
        int ef = -1;
        int k  = -1;
        for (int i = 0; i < NF; i++) begin
            if (mq[i].size() == 0) begin
                if (ef < 0) ef = i;
            end else if (mi[i] == idx) begin
                bf = i;
            end
        end
        if (bf >= 0) begin
            f = bf;
            for (int s = 0; s < mq[bf].size(); s++) if (mq[bf][s].tag == tag) k = s;
            if (k >= 0) kind = (mbusy && msel == bf && k == 0) ? 0 : 1;
            else        kind = (mq[bf].size() < FS) ? 2 : 0;
        end else begin
            f    = ef;
            kind = (ef >= 0) ? 3 : 0;
        end
    endtask

    task automatic m_step(input logic wen, input logic [4:0] idx, input logic [7:0] tag,
                          input logic [63:0] d, input logic ack);
        int   kind, f, pick, osel;
        ent_t e;
        bit   pop;
        m_classify(idx, tag, kind, f);
        pop  = mbusy && ack;
        pick = -1;
        if (!mbusy) begin
            for (int i = 0; i < NF; i++)
                if (pick < 0 && mq[(mrr + i) % NF].size() > 0) pick = (mrr + i) % NF;
        end
        if (pick >= 0) begin
            mreq  = 1;
            maddr = {mq[pick][0].tag, mi[pick]};
            mdata = mq[pick][0].data;
        end
        osel = msel;
        if (pop) begin
            e     = mq[osel].pop_front();
            mbusy = 0;
            mreq  = 0;
            mrr   = (osel + 1) % NF;
        end
        if (pick >= 0) begin
            mbusy = 1;
            msel  = pick;
        end
        if (wen && kind != 0) begin
            e.tag  = tag;
            e.data = d;
            if (kind == 1) begin
                for (int s = 0; s < mq[f].size(); s++)
                    if (mq[f][s].tag == tag) mq[f][s] = e;
            end else begin
                if (kind == 3) mi[f] = idx;
                mq[f].push_back(e);
            end
        end
    endtask

    function automatic logic [FS*EW-1:0] exp_row(int f);
        logic [FS*EW-1:0] r = '0;
        for (int s = 0; s < mq[f].size(); s++) r[s*EW +: EW] = {mi[f], mq[f][s].tag, mq[f][s].data};
        return r;
    endfunction

    function automatic logic [FS-1:0] exp_vld(int f);
        logic [FS-1:0] v = '0;
        for (int s = 0; s < mq[f].size(); s++) v[s] = 1'b1;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic wen, input logic [4:0] idx, input logic [7:0] tag,
                         input logic [63:0] d, input logic ack);
        wr_en = wen; wr_index = idx; wr_tag = tag; wr_data = d; mem_ack = ack;
    endtask

    task automatic cycle(input logic wen, input logic [4:0] idx, input logic [7:0] tag,
                         input logic [63:0] d, input logic ack);
        drive(wen, idx, tag, d, ack);
        @(posedge clock);
        #1;
        drive(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        reset = 1'b0;
        m_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  idx;
        logic [7:0]  tag;
        logic [63:0] data;
        logic        ack;
        logic        exp_ready;
        logic [3:0]  exp_v0;
        logic [3:0]  exp_v1;
        logic        exp_req;
        logic [12:0] exp_addr;
    } vec_t;

    vec_t       vecs [12];
    logic [4:0] idx_pool [6];

    initial begin
        // Fill idx 3, overflow, allocate idx 7, coalesce, locked head, drain, round-robin.
        vecs[0]  = '{1'b1, 5'd3, 8'd1, 64'h101, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 13'h000};
        vecs[1]  = '{1'b1, 5'd3, 8'd2, 64'h102, 1'b0, 1'b1, 4'b0011, 4'b0000, 1'b1, 13'h023};
        vecs[2]  = '{1'b1, 5'd3, 8'd3, 64'h103, 1'b0, 1'b1, 4'b0111, 4'b0000, 1'b1, 13'h023};
        vecs[3]  = '{1'b1, 5'd3, 8'd4, 64'h104, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 13'h023};
        vecs[4]  = '{1'b1, 5'd3, 8'd5, 64'h105, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 13'h023};
        vecs[5]  = '{1'b1, 5'd7, 8'd1, 64'h701, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 13'h023};
        vecs[6]  = '{1'b1, 5'd3, 8'd2, 64'h055, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 13'h023};
        vecs[7]  = '{1'b1, 5'd3, 8'd1, 64'h077, 1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 13'h023};
        vecs[8]  = '{1'b1, 5'd3, 8'd1, 64'h077, 1'b1, 1'b0, 4'b0111, 4'b0001, 1'b0, 13'h023};
        vecs[9]  = '{1'b1, 5'd3, 8'd1, 64'h077, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 13'h027};
        vecs[10] = '{1'b0, 5'd0, 8'd0, 64'h000, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 13'h027};
        vecs[11] = '{1'b0, 5'd0, 8'd0, 64'h000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 13'h043};
        idx_pool = '{5'd3, 5'd7, 5'd9, 5'd12, 5'd20, 5'd1};

        // Reset state
        drive(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("reset all_empty", 512'(all_empty), 512'(1'b1));
        chk("reset mem_req", 512'(mem_req), 512'(1'b0));
        chk("reset mem_addr", 512'(mem_addr), 512'(13'h0));
        chk("reset mem_data", 512'(mem_data), 512'(64'h0));
        chk("reset valid", 512'(vld), 512'(16'h0));
        chk("reset wr_ready", 512'(wr_ready), 512'(1'b1));
        for (int f = 0; f < NF; f++) chk("reset fifo row", 512'(fifo_out[f]), 512'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wen, vecs[i].idx, vecs[i].tag, vecs[i].data, vecs[i].ack);
            @(negedge clock);
            chk($sformatf("vec%0d wr_ready", i), 512'(wr_ready), 512'(vecs[i].exp_ready));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d valid0", i), 512'(vld[0]), 512'(vecs[i].exp_v0));
            chk($sformatf("vec%0d valid1", i), 512'(vld[1]), 512'(vecs[i].exp_v1));
            chk($sformatf("vec%0d mem_req", i), 512'(mem_req), 512'(vecs[i].exp_req));
            if (vecs[i].exp_req) chk($sformatf("vec%0d mem_addr", i), 512'(mem_addr), 512'(vecs[i].exp_addr));
        end

        // First write: 1-cycle storage latency, request one cycle later
        do_reset();
        cycle(1'b1, 5'd3, 8'h12, 64'hAAAA, 1'b0);
        chk("first slot", 512'(fifo_out[0][0]), 512'({5'd3, 8'h12, 64'hAAAA}));
        chk("first valid", 512'(vld[0][0]), 512'(1'b1));
        chk("first no req yet", 512'(mem_req), 512'(1'b0));
        cycle(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        chk("first req", 512'(mem_req), 512'(1'b1));
        chk("first addr", 512'(mem_addr), 512'({8'h12, 5'd3}));
        chk("first data", 512'(mem_data), 512'(64'hAAAA));

        // Coalesce non-head, then pop shifts down and zeroes the tail
        do_reset();
        cycle(1'b1, 5'd3, 8'd1, 64'h11, 1'b0);
        cycle(1'b1, 5'd3, 8'd2, 64'h22, 1'b0);
        cycle(1'b1, 5'd3, 8'd3, 64'h33, 1'b0);
        cycle(1'b1, 5'd3, 8'd2, 64'h55, 1'b0);
        chk("coal slot1", 512'(fifo_out[0][1]), 512'({5'd3, 8'd2, 64'h55}));
        chk("coal valid", 512'(vld[0]), 512'(4'b0111));
        cycle(1'b0, 5'd0, 8'd0, 64'd0, 1'b1);
        chk("pop slot0", 512'(fifo_out[0][0]), 512'({5'd3, 8'd2, 64'h55}));
        chk("pop slot1", 512'(fifo_out[0][1]), 512'({5'd3, 8'd3, 64'h33}));
        chk("pop slot2 zero", 512'(fifo_out[0][2]), 512'(0));
        chk("pop valid", 512'(vld[0]), 512'(4'b0011));
        chk("pop req drop", 512'(mem_req), 512'(1'b0));

        // Pop emptying a FIFO while appending to it on the same edge
        do_reset();
        cycle(1'b1, 5'd3, 8'd1, 64'h11, 1'b0);
        cycle(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        chk("simul req", 512'(mem_req), 512'(1'b1));
        drive(1'b1, 5'd3, 8'd9, 64'h99, 1'b1);
        @(negedge clock);
        chk("simul wr_ready", 512'(wr_ready), 512'(1'b1));
        @(posedge clock);
        #1;
        drive(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        chk("simul slot0", 512'(fifo_out[0][0]), 512'({5'd3, 8'd9, 64'h99}));
        chk("simul valid", 512'(vld[0]), 512'(4'b0001));
        chk("simul not empty", 512'(all_empty), 512'(1'b0));
        cycle(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        chk("simul next addr", 512'(mem_addr), 512'({8'd9, 5'd3}));

        // All FIFOs bound, no room for a new index, then async reset mid-DRAIN
        do_reset();
        cycle(1'b1, 5'd1, 8'd1, 64'h1, 1'b0);
        cycle(1'b1, 5'd2, 8'd1, 64'h2, 1'b0);
        cycle(1'b1, 5'd4, 8'd1, 64'h4, 1'b0);
        cycle(1'b1, 5'd5, 8'd1, 64'h5, 1'b0);
        drive(1'b1, 5'd6, 8'd1, 64'h6, 1'b0);
        #1;
        chk("no free fifo", 512'(wr_ready), 512'(1'b0));
        chk("pre-reset req", 512'(mem_req), 512'(1'b1));
        drive(1'b0, 5'd0, 8'd0, 64'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("async req drop", 512'(mem_req), 512'(1'b0));
        chk("async valid", 512'(vld), 512'(16'h0));
        chk("async empty", 512'(all_empty), 512'(1'b1));
        for (int f = 0; f < NF; f++) chk("async fifo row", 512'(fifo_out[f]), 512'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        wen, ack;
            logic [4:0]  idx;
            logic [7:0]  tag;
            logic [63:0] d;
            int          kind, f;
            wen = ($urandom_range(0, 9) < 7);
            ack = ($urandom_range(0, 9) < 4);
            idx = idx_pool[$urandom_range(0, 5)];
            tag = 8'($urandom_range(0, 5));
            d   = {$urandom, $urandom};
            m_classify(idx, tag, kind, f);
            drive(wen, idx, tag, d, ack);
            @(negedge clock);
            chk("rand wr_ready", 512'(wr_ready), 512'(kind != 0));
            m_step(wen, idx, tag, d, ack);
            @(posedge clock);
            #1;
            for (int r = 0; r < NF; r++) begin
                chk($sformatf("rand fifo%0d", r), 512'(fifo_out[r]), 512'(exp_row(r)));
                chk($sformatf("rand valid%0d", r), 512'(vld[r]), 512'(exp_vld(r)));
            end
            chk("rand mem_req", 512'(mem_req), 512'(mreq));
            chk("rand mem_addr", 512'(mem_addr), 512'(maddr));
            chk("rand mem_data", 512'(mem_data), 512'(mdata));
            chk("rand all_empty", 512'(all_empty),
                512'(mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_fifo_writer.md
Name: dcache_fifo_writer

Overview:
- Write side of the dcache store/victim FIFO structure.
- Accepts store/evict entries {set index, tag, 64-bit data} and sorts them into NUM_FIFO per-set FIFOs. Each FIFO is bound to one set index while non-empty.
- Coalesces same-address writes and drains FIFO heads to memory over a req/ack handshake.
- Presents the FIFO contents in the packed layout the dcache lookup consumes: index in slot 0, tag/data per slot.

Parameters:
- NUM_FIFO, 4, number of per-set FIFOs.
- FIFO_SIZE, 4, entries per FIFO.
- NUM_SET_BITS, 5, set index width.
- NUM_TAG_BITS, 8, tag width.
- ENTRY_W, NUM_SET_BITS+NUM_TAG_BITS+64, packed entry width: {index, tag, data}, index in MSBs, data in [63:0].

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_index  in  NUM_SET_BITS  set index of write.
- wr_tag  in  NUM_TAG_BITS  tag of write.
- wr_data  in  64  write data.
- wr_ready  out  1  write accepted this cycle when wr_en && wr_ready (combinational).
- FIFO  out  NUM_FIFO x FIFO_SIZE x ENTRY_W  packed FIFO contents, registered.
- fifo_entry_valid  out  NUM_FIFO x FIFO_SIZE  per-slot valid, registered.
- mem_req  out  1  drain request.
- mem_addr  out  NUM_TAG_BITS+NUM_SET_BITS  {tag, index} of head being drained.
- mem_data  out  64  data of head being drained.
- mem_ack  in  1  memory accepted the request.
- all_empty  out  1  no valid entries anywhere.

Behaviour:
- Reset (reset==0, async): all FIFO slots zero, all valid bits 0, counts 0, FSM IDLE, rr pointer 0, mem_req 0, mem_addr/mem_data 0, all_empty 1. wr_ready evaluates from the cleared state.
- Storage invariants:
  - Each FIFO is compacted: valid slots are 0..count-1, slot 0 is the head.
  - Invalid slots hold all-zero.
  - The index field is written into every slot of the FIFO.
  - A FIFO is bound to an index iff count>0.
  - No two valid slots in the system share {index, tag}.
- Write classification (combinational, wr_en high):
  - Coalesce: some valid slot matches {wr_index, wr_tag}. Overwrite that slot's data. If that slot is the head currently locked by DRAIN, wr_ready=0.
  - Append: a bound FIFO has index==wr_index and count<FIFO_SIZE. Write at slot count; count+1.
  - Allocate: no bound FIFO for wr_index and an empty FIFO exists. Use the lowest-numbered empty FIFO, slot 0; count=1.
  - Otherwise (bound FIFO full, or no empty FIFO): wr_ready=0.
- Write results appear on FIFO/fifo_entry_valid the cycle after acceptance (1-cycle latency).
- Drain FSM:
  - IDLE: if any FIFO is non-empty, select the first non-empty FIFO at or after rr pointer (wrapping), latch its head into mem_addr/mem_data, assert mem_req, go to DRAIN.
  - DRAIN: mem_req, mem_addr and mem_data are held stable. The head is locked: a coalesce to it stalls, and appends behind it are allowed.
  - DRAIN on mem_ack: next edge pops the head. Slots shift down by one; the last slot is zeroed; count-1. rr pointer moves to selected+1 mod NUM_FIFO. mem_req drops and the FSM returns to IDLE.
  - Minimum one IDLE cycle between requests.
  - A FIFO reaching count 0 is unbound and becomes eligible for allocation the following cycle.
- Simultaneous pop and write, same FIFO, same edge:
  - Pop shift is applied first.
  - An append lands at slot count-1 (post-shift position).
  - A coalesce to a non-head slot k lands at slot k-1.
  - Count = count unchanged for append.
  - If the pop empties the FIFO and the same edge writes an append, the FIFO stays bound and holds the new entry at slot 0.
- mem_ack while IDLE is ignored.
- Reset mid-DRAIN discards the entry; mem_req drops immediately (async).
- all_empty = no valid bits set, registered.
- Width rules: counts are clog2(FIFO_SIZE+1) bits; the rr pointer wraps modulo NUM_FIFO.

Test Plan:
- Reset, then write (idx 3, tag 0x12, data 0xAAAA), mem_ack held 0 → next cycle FIFO[0][0] = {3, 0x12, 0xAAAA}, valid[0][0]=1. mem_req=1 one cycle later with mem_addr={0x12, 3} and mem_data=0xAAAA.
- Fill idx 3 with tags 1..4 while mem_ack=0 → FIFO 0 full. A fifth write idx 3 tag 5 gets wr_ready=0. A write idx 7 tag 1 allocates FIFO 1 slot 0.
- Coalesce: write idx 3 tag 2 data 0x55 over an existing non-head entry → same slot now holds 0x55, count unchanged. Same write targeting the locked head tag 1 → wr_ready=0 until the cycle after mem_ack.
- Drain: pulse mem_ack with FIFO 0 holding tags 1,2,3 → next cycle slot0=tag 2, slot1=tag 3, slot2 zeroed and invalid. The following request is taken from FIFO 1 (round-robin), not FIFO 0.
- Simultaneous: FIFO 0 at count 1 under DRAIN; mem_ack and an append write (idx 3, tag 9) on the same edge → FIFO 0 count 1, slot0=tag 9, still bound to idx 3.
- Assert reset low mid-DRAIN with all FIFOs populated → mem_req=0 immediately, all valid=0, all_empty=1, FIFO all zero.
